edge_frame_ctrl: RTL and testbench

Frame sequencer for the RGB565 edge-detection datapath. Pops pixels from the first-word-fall-through capture FIFO and feeds them to the edge processor as a qualified pixel stream. Counts pixel position within the frame and inserts horizontal blanking between lines. Latches the edge threshold only at frame boundaries and flags frame start, line end and frame end to downstream logic.

---
 rtl/edge_frame_ctrl.sv | 254 +++++++++++++++++++++++++
 tb/tb_edge_frame_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_frame_ctrl.sv
// ---------------------------------------------------------------------------
// edge_frame_ctrl
//
// Frame sequencer for the RGB565 edge-detection datapath. Pops pixels from a
// first-word-fall-through capture FIFO and presents them to the edge
// processor as a qualified pixel stream. It tracks pixel position, inserts
// horizontal blanking after each line, latches the edge threshold only at
// frame boundaries, and flags frame start / line end / frame end.
//
// Optional feature: define EDGE_CTRL_WATCHDOG_EN to enable the ACTIVE-state
// stall watchdog. Without it, err_stall is tied low and ACTIVE waits for the
// FIFO indefinitely.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             one-cycle pulse, starts a frame from IDLE only
//   cont              continuous mode, sampled in DONE
//   abort             abandon the frame, return to IDLE (highest priority)
//   cfg_threshold/wr  shadow threshold write (takes effect at next ARM)
//   fifo_empty/dout   capture FIFO status and head word
//   fifo_rd_en        FIFO pop (combinational)
//   out_ready         downstream sink can accept a result
//   proc_pixel/valid  registered pixel stream to the processor
//   proc_threshold    active threshold
//   sof/eol/eof       frame/line markers, aligned with proc_valid
//   busy              state != IDLE
//   frame_done        one-cycle pulse in DONE
//   err_stall         sticky watchdog flag
//
// State    | Meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for start
// ARM      | load threshold from shadow, clear position counters
// ACTIVE   | pop and forward pixels while FIFO non-empty and sink ready
// HBLANK   | H_BLANK idle cycles between lines, no pops
// DONE     | frame_done pulse, then ARM (cont) or IDLE
// ---------------------------------------------------------------------------
module edge_frame_ctrl #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned H_BLANK     = 4,
  parameter int unsigned STALL_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        cont,
  input  logic        abort,
  input  logic [2:0]  cfg_threshold,
  input  logic        cfg_wr,
  input  logic        fifo_empty,
  input  logic [15:0] fifo_dout,
  output logic        fifo_rd_en,
  input  logic        out_ready,
  output logic [15:0] proc_pixel,
  output logic        proc_valid,
  output logic [2:0]  proc_threshold,
  output logic        sof,
  output logic        eol,
  output logic        eof,
  output logic        busy,
  output logic        frame_done,
  output logic        err_stall
);

  localparam int unsigned XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int unsigned YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int unsigned BW = (H_BLANK > 1) ? $clog2(H_BLANK) : 1;

  localparam logic [XW-1:0] X_LAST     = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST     = YW'(V_ACTIVE - 1);
  localparam logic [BW-1:0] BLANK_LOAD = BW'(H_BLANK - 1);

  if (H_BLANK < 1 || STALL_LIMIT < 1) begin : g_param_check
    $error("edge_frame_ctrl: H_BLANK and STALL_LIMIT must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_ACTIVE = 3'd2,
    S_HBLANK = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [BW-1:0] blank_q, blank_d;
  logic [15:0]   pixel_q, pixel_d;
  logic          valid_q, valid_d;
  logic          sof_q, sof_d;
  logic          eol_q, eol_d;
  logic          eof_q, eof_d;
  logic [2:0]    thr_q, thr_d;
  logic [2:0]    shadow_q, shadow_d;

  logic issue_raw;
  logic issue;
  logic wd_trip;

  // Pop opportunity before abort gating; the watchdog watches this so an
  // abort in the same cycle cannot be mistaken for a stall.
  assign issue_raw = (state_q == S_ACTIVE) && !fifo_empty && out_ready;
  // No pop on an abort cycle: the word stays in the FIFO for the next frame.
  assign issue     = issue_raw && !abort;

`ifdef EDGE_CTRL_WATCHDOG_EN
  localparam int unsigned SW = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
  localparam logic [SW-1:0] WD_LOAD = SW'(STALL_LIMIT - 1);

  logic [SW-1:0] wd_q, wd_d;
  logic          err_q, err_d;

  // Down-counter reloaded on every issue and outside ACTIVE; terminal count
  // is reached on the STALL_LIMIT-th consecutive idle ACTIVE cycle.
  always_comb begin
    wd_d    = WD_LOAD;
    wd_trip = 1'b0;
    err_d   = err_q;
    if (state_q == S_ACTIVE && !issue_raw) begin
      if (wd_q == '0) wd_trip = 1'b1;
      else            wd_d    = wd_q - 1'b1;
    end
    if (wd_trip)                         err_d = 1'b1;
    else if (state_q == S_IDLE && start) err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q  <= WD_LOAD;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign err_stall = err_q;
`else
  assign wd_trip   = 1'b0;
  assign err_stall = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    blank_d  = blank_q;
    pixel_d  = pixel_q;
    valid_d  = 1'b0;
    sof_d    = 1'b0;
    eol_d    = 1'b0;
    eof_d    = 1'b0;
    thr_d    = thr_q;
    shadow_d = cfg_wr ? cfg_threshold : shadow_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_ARM;
      end
      S_ARM: begin
        // shadow_d gives write-through when cfg_wr lands on the ARM cycle
        thr_d   = shadow_d;
        x_d     = '0;
        y_d     = '0;
        state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (issue) begin
          pixel_d = fifo_dout;
          valid_d = 1'b1;
          sof_d   = (x_q == '0) && (y_q == '0);
          eol_d   = (x_q == X_LAST);
          eof_d   = (x_q == X_LAST) && (y_q == Y_LAST);
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
              y_d     = '0;
              state_d = S_DONE;
            end else begin
              y_d     = y_q + 1'b1;
              blank_d = BLANK_LOAD;
              state_d = S_HBLANK;
            end
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      S_HBLANK: begin
        if (blank_q == '0) state_d = S_ACTIVE;
        else               blank_d = blank_q - 1'b1;
      end
      S_DONE: begin
        state_d = cont ? S_ARM : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort (external or watchdog) overrides everything but the shadow
    // register and the sticky stall flag.
    if (abort || wd_trip) begin
      state_d = S_IDLE;
      x_d     = '0;
      y_d     = '0;
      valid_d = 1'b0;
      sof_d   = 1'b0;
      eol_d   = 1'b0;
      eof_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      blank_q  <= '0;
      pixel_q  <= '0;
      valid_q  <= 1'b0;
      sof_q    <= 1'b0;
      eol_q    <= 1'b0;
      eof_q    <= 1'b0;
      thr_q    <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      blank_q  <= blank_d;
      pixel_q  <= pixel_d;
      valid_q  <= valid_d;
      sof_q    <= sof_d;
      eol_q    <= eol_d;
      eof_q    <= eof_d;
      thr_q    <= thr_d;
      shadow_q <= shadow_d;
    end
  end

  assign fifo_rd_en     = issue;
  assign proc_pixel     = pixel_q;
  assign proc_valid     = valid_q;
  assign proc_threshold = thr_q;
  assign sof            = sof_q;
  assign eol            = eol_q;
  assign eof            = eof_q;
  assign busy           = (state_q != S_IDLE);
  assign frame_done     = (state_q == S_DONE);

endmodule

// File: tb/tb_edge_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_edge_frame_ctrl
//
// Directed bench for edge_frame_ctrl with H_ACTIVE=4, V_ACTIVE=2, H_BLANK=2,
// STALL_LIMIT=8. A small FWFT FIFO model feeds the DUT. Per-cycle tables
// cover the nominal frame and the out_ready stall; hand-written sequences
// cover threshold shadowing, abort/restart and the stall watchdog
// (EDGE_CTRL_WATCHDOG_EN selects the watchdog expectations).
// ---------------------------------------------------------------------------
module tb_edge_frame_ctrl;

  localparam int unsigned H_ACTIVE    = 4;
  localparam int unsigned V_ACTIVE    = 2;
  localparam int unsigned H_BLANK     = 2;
  localparam int unsigned STALL_LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cont = 1'b0;
  logic        abort = 1'b0;
  logic [2:0]  cfg_threshold = 3'd0;
  logic        cfg_wr = 1'b0;
  logic        fifo_empty;
  logic [15:0] fifo_dout;
  logic        fifo_rd_en;
  logic        out_ready = 1'b1;
  logic [15:0] proc_pixel;
  logic        proc_valid;
  logic [2:0]  proc_threshold;
  logic        sof, eol, eof;
  logic        busy;
  logic        frame_done;
  logic        err_stall;

  int n_chk  = 0;
  int n_fail = 0;

  // FWFT FIFO model
  logic [15:0] mem [64];
  int          wr_ptr = 0;
  int          rd_ptr = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_dout  = mem[rd_ptr % 64];

  always @(posedge clk) begin
    if (rst_n && fifo_rd_en && (wr_ptr != rd_ptr)) rd_ptr <= rd_ptr + 1;
  end

  always #5 clk = ~clk;

  edge_frame_ctrl #(
    .H_ACTIVE   (H_ACTIVE),
    .V_ACTIVE   (V_ACTIVE),
    .H_BLANK    (H_BLANK),
    .STALL_LIMIT(STALL_LIMIT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .cont          (cont),
    .abort         (abort),
    .cfg_threshold (cfg_threshold),
    .cfg_wr        (cfg_wr),
    .fifo_empty    (fifo_empty),
    .fifo_dout     (fifo_dout),
    .fifo_rd_en    (fifo_rd_en),
    .out_ready     (out_ready),
    .proc_pixel    (proc_pixel),
    .proc_valid    (proc_valid),
    .proc_threshold(proc_threshold),
    .sof           (sof),
    .eol           (eol),
    .eof           (eof),
    .busy          (busy),
    .frame_done    (frame_done),
    .err_stall     (err_stall)
  );

  typedef struct {
    logic        st;
    logic        rdy;
    logic        rd;
    logic        v;
    logic [15:0] px;
    logic        sof;
    logic        eol;
    logic        eof;
    logic        fd;
    logic        busy;
  } vec_t;

  vec_t ta[$];
  vec_t tb[$];

  function automatic vec_t mk(logic st, logic rdy, logic rd, logic v,
                              logic [15:0] px, logic s, logic l, logic e,
                              logic fd, logic bz);
    vec_t r;
    r.st = st; r.rdy = rdy; r.rd = rd; r.v = v; r.px = px;
    r.sof = s; r.eol = l; r.eof = e; r.fd = fd; r.busy = bz;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    mem[wr_ptr % 64] = w;
    wr_ptr++;
  endtask

  task automatic run_table(input string tag, input vec_t t[$]);
    for (int i = 0; i < t.size(); i++) begin
      tick();
      start     = t[i].st;
      out_ready = t[i].rdy;
      #1;
      chk($sformatf("%s[%0d] fifo_rd_en", tag, i), fifo_rd_en, t[i].rd);
      chk($sformatf("%s[%0d] proc_valid", tag, i), proc_valid, t[i].v);
      if (t[i].v)
        chk($sformatf("%s[%0d] proc_pixel", tag, i), proc_pixel, t[i].px);
      chk($sformatf("%s[%0d] sof", tag, i), sof, t[i].sof);
      chk($sformatf("%s[%0d] eol", tag, i), eol, t[i].eol);
      chk($sformatf("%s[%0d] eof", tag, i), eof, t[i].eof);
      chk($sformatf("%s[%0d] frame_done", tag, i), frame_done, t[i].fd);
      chk($sformatf("%s[%0d] busy", tag, i), busy, t[i].busy);
    end
    start     = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic        fd_seen;
    logic [15:0] eof_px;
    int          k;

    // nominal frame: st rdy | rd v px sof eol eof fd busy
    ta.push_back(mk(1,1, 0,0,16'h0000, 0,0,0, 0,0));
    ta.push_back(mk(0,1, 0,0,16'h0000, 0,0,0, 0,1));
    ta.push_back(mk(0,1, 1,0,16'h0000, 0,0,0, 0,1));
    ta.push_back(mk(0,1, 1,1,16'h0001, 1,0,0, 0,1));
    ta.push_back(mk(0,1, 1,1,16'h0002, 0,0,0, 0,1));
    ta.push_back(mk(0,1, 1,1,16'h0003, 0,0,0, 0,1));
    ta.push_back(mk(0,1, 0,1,16'h0004, 0,1,0, 0,1));
    ta.push_back(mk(0,1, 0,0,16'h0000, 0,0,0, 0,1));
    ta.push_back(mk(0,1, 1,0,16'h0000, 0,0,0, 0,1));
    ta.push_back(mk(0,1, 1,1,16'h0005, 0,0,0, 0,1));
    ta.push_back(mk(0,1, 1,1,16'h0006, 0,0,0, 0,1));
    ta.push_back(mk(0,1, 1,1,16'h0007, 0,0,0, 0,1));
    ta.push_back(mk(0,1, 0,1,16'h0008, 0,1,1, 1,1));
    ta.push_back(mk(0,1, 0,0,16'h0000, 0,0,0, 0,0));

    // out_ready low for 3 cycles after the 2nd pop
    tb.push_back(mk(1,1, 0,0,16'h0000, 0,0,0, 0,0));
    tb.push_back(mk(0,1, 0,0,16'h0000, 0,0,0, 0,1));
    tb.push_back(mk(0,1, 1,0,16'h0000, 0,0,0, 0,1));
    tb.push_back(mk(0,1, 1,1,16'h0001, 1,0,0, 0,1));
    tb.push_back(mk(0,0, 0,1,16'h0002, 0,0,0, 0,1));
    tb.push_back(mk(0,0, 0,0,16'h0000, 0,0,0, 0,1));
    tb.push_back(mk(0,0, 0,0,16'h0000, 0,0,0, 0,1));
    tb.push_back(mk(0,1, 1,0,16'h0000, 0,0,0, 0,1));
    tb.push_back(mk(0,1, 1,1,16'h0003, 0,0,0, 0,1));
    tb.push_back(mk(0,1, 0,1,16'h0004, 0,1,0, 0,1));
    tb.push_back(mk(0,1, 0,0,16'h0000, 0,0,0, 0,1));
    tb.push_back(mk(0,1, 1,0,16'h0000, 0,0,0, 0,1));
    tb.push_back(mk(0,1, 1,1,16'h0005, 0,0,0, 0,1));
    tb.push_back(mk(0,1, 1,1,16'h0006, 0,0,0, 0,1));
    tb.push_back(mk(0,1, 1,1,16'h0007, 0,0,0, 0,1));
    tb.push_back(mk(0,1, 0,1,16'h0008, 0,1,1, 1,1));
    tb.push_back(mk(0,1, 0,0,16'h0000, 0,0,0, 0,0));

    // reset values
    #12;
    chk("rst proc_valid", proc_valid, 0);
    chk("rst proc_pixel", proc_pixel, 0);
    chk("rst proc_threshold", proc_threshold, 0);
    chk("rst markers", {sof, eol, eof}, 0);
    chk("rst frame_done", frame_done, 0);
    chk("rst busy", busy, 0);
    chk("rst err_stall", err_stall, 0);
    chk("rst fifo_rd_en", fifo_rd_en, 0);
    tick();
    rst_n = 1'b1;

    // nominal frame
    for (int i = 1; i <= 8; i++) push(16'(i));
    run_table("frame", ta);

    // out_ready stall mid-line
    for (int i = 1; i <= 8; i++) push(16'(i));
    run_table("stall", tb);

    // threshold shadowing across a continuous-mode frame boundary
    tick();
    cfg_threshold = 3'd2;
    cfg_wr        = 1'b1;
    tick();
    cfg_wr = 1'b0;
    for (int i = 0; i < 16; i++) push(16'h0011 + 16'(i));
    for (int c = 0; c <= 14; c++) begin
      tick();
      start  = (c == 0);
      cont   = (c < 14);
      cfg_wr = (c == 4);
      if (c == 4) cfg_threshold = 3'd5;
      #1;
      if (c >= 2 && c <= 13)
        chk($sformatf("thr_hold[%0d]", c), proc_threshold, 2);
      if (c == 12) chk("thr frame_done", frame_done, 1);
      if (c == 14) chk("thr_next_frame", proc_threshold, 5);
    end
    cfg_wr = 1'b0;
    k = 0;
    while (busy && k < 40) begin tick(); k++; end
    chk("thr frame2 finish busy", busy, 0);
    chk("thr frame2 fifo drained", fifo_empty, 1);

    // cfg_wr on the ARM cycle writes through
    tick(); start = 1'b1;
    tick(); start = 1'b0; cfg_threshold = 3'd6; cfg_wr = 1'b1;
    tick(); cfg_wr = 1'b0;
    #1;
    chk("thr write_through", proc_threshold, 6);
    abort = 1'b1;
    tick(); abort = 1'b0;
    #1;
    chk("wt abort busy", busy, 0);

    // abort while the 3rd pixel is on proc_pixel, then restart
    for (int i = 1; i <= 8; i++) push(16'(i));
    fd_seen = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      tick();
      start = (c == 0) || (c == 7);
      abort = (c == 5);
      #1;
      if (c >= 5 && frame_done) fd_seen = 1'b1;
      if (c == 5) begin
        chk("abort px3 on output", proc_pixel, 16'h0003);
        chk("abort no pop", fifo_rd_en, 0);
      end
      if (c == 6) begin
        chk("abort busy", busy, 0);
        chk("abort proc_valid", proc_valid, 0);
      end
      if (c == 10) begin
        chk("restart proc_valid", proc_valid, 1);
        chk("restart pixel", proc_pixel, 16'h0004);
        chk("restart sof", sof, 1);
        chk("abort no frame_done", fd_seen, 0);
        push(16'h0009); push(16'h000A); push(16'h000B);
      end
    end
    start  = 1'b0;
    abort  = 1'b0;
    fd_seen = 1'b0;
    eof_px  = 16'hFFFF;
    k = 0;
    while (busy && k < 40) begin
      if (proc_valid && eof) eof_px = proc_pixel;
      if (frame_done) fd_seen = 1'b1;
      tick(); k++;
    end
    chk("restart frame_done", fd_seen, 1);
    chk("restart eof pixel", eof_px, 16'h000B);
    chk("restart finish busy", busy, 0);

    // watchdog: FIFO runs dry after two pixels
    push(16'h0031); push(16'h0032);
    for (int c = 0; c <= 12; c++) begin
      tick();
      start = (c == 0);
      #1;
      if (c == 11) begin
        chk("wd pre busy", busy, 1);
        chk("wd pre err_stall", err_stall, 0);
      end
      if (c == 12) begin
        chk("wd frame_done", frame_done, 0);
`ifdef EDGE_CTRL_WATCHDOG_EN
        chk("wd busy", busy, 0);
        chk("wd err_stall", err_stall, 1);
`else
        chk("wd busy", busy, 1);
        chk("wd err_stall", err_stall, 0);
`endif
      end
    end
    start = 1'b0;
`ifdef EDGE_CTRL_WATCHDOG_EN
    tick(); start = 1'b1;
    tick(); start = 1'b0;
    #1;
    chk("wd err cleared by start", err_stall, 0);
    chk("wd restart busy", busy, 1);
`else
    for (int c = 0; c < 20; c++) tick();
    chk("no wd still busy", busy, 1);
`endif
    tick(); abort = 1'b1;
    tick(); abort = 1'b0;
    #1;
    chk("wd final abort busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
